// File: rtl/ex_stage_pkg.sv
// Shared definitions for the MIPS execute stage: bus widths, ALU op bit
// positions, SPECIAL function codes, divider states and the ID/EX layout.
package ex_stage_pkg;

  localparam int ID_TO_EX_WD  = 160;
  localparam int EX_TO_MEM_WD = 76;
  localparam int EX_TO_RF_WD  = 38;
  localparam int DIV_CYCLES   = 32;

  // StallBus indices (1 = stop)
  localparam int STALL_ID = 2;
  localparam int STALL_EX = 3;

  // alu_op bit positions, MSB first: {add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui}
  localparam int OP_ADD  = 11;
  localparam int OP_SUB  = 10;
  localparam int OP_SLT  = 9;
  localparam int OP_SLTU = 8;
  localparam int OP_AND  = 7;
  localparam int OP_NOR  = 6;
  localparam int OP_OR   = 5;
  localparam int OP_XOR  = 4;
  localparam int OP_SLL  = 3;
  localparam int OP_SRL  = 2;
  localparam int OP_SRA  = 1;
  localparam int OP_LUI  = 0;

  // SPECIAL (opcode 0) function codes touching HI/LO
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // ID/EX register layout, MSB to LSB, matching id_to_ex_bus
  typedef struct packed {
    logic        reserved;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  sel_src1;
    logic [3:0]  sel_src2;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
  } id_ex_t;

  // Two's-complement negate when n is set
  function automatic logic [31:0] neg_if(input logic n, input logic [31:0] v);
    return n ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_stage_div_iter.sv
// Iterative restoring divider, one quotient bit per cycle.
// IDLE -> BUSY on start (operand setup), BUSY for DIV_CYCLES cycles, DONE for
// one cycle with quotient/remainder valid, then back to IDLE.
module ex_stage_div_iter
  import ex_stage_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        idle,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam int CNT_W = $clog2(DIV_CYCLES);

  div_state_e       state;
  logic [CNT_W-1:0] count;
  logic [31:0]      quo;
  logic [31:0]      rem;
  logic [31:0]      divs;
  logic [31:0]      raw_dividend;
  logic             q_neg;
  logic             r_neg;
  logic             div_zero;

  logic [32:0]      shifted;
  logic [32:0]      trial;

  // One restoring step: shift in the next dividend bit, subtract if it fits
  assign shifted = {rem, quo[31]};
  assign trial   = shifted - {1'b0, divs};

  // Divider FSM and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the operand registers are reset too; they are few and a
      // known state keeps quotient/remainder deterministic after reset.
      state        <= DIV_IDLE;
      count        <= '0;
      quo          <= '0;
      rem          <= '0;
      divs         <= '0;
      raw_dividend <= '0;
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
      div_zero     <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every register
      // samples pre-edge values regardless of statement order.
      unique case (state)
        DIV_IDLE: begin
          if (start) begin
            quo          <= neg_if(is_signed & dividend[31], dividend);
            divs         <= neg_if(is_signed & divisor[31], divisor);
            raw_dividend <= dividend;
            q_neg        <= is_signed & (dividend[31] ^ divisor[31]);
            r_neg        <= is_signed & dividend[31];
            div_zero     <= (divisor == 32'd0);
            rem          <= '0;
            count        <= '0;
            state        <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          if (!trial[32]) begin
            rem <= trial[31:0];
            quo <= {quo[30:0], 1'b1};
          end else begin
            rem <= shifted[31:0];
            quo <= {quo[30:0], 1'b0};
          end
          count <= count + CNT_W'(1);
          if (count == CNT_W'(DIV_CYCLES - 1)) state <= DIV_DONE;
        end
        DIV_DONE: state <= DIV_IDLE;
        default:  state <= DIV_IDLE;
      endcase
    end
  end

  assign idle = (state == DIV_IDLE);
  assign busy = (state == DIV_BUSY);
  assign done = (state == DIV_DONE);

  // Sign correction; divide by zero yields all-ones quotient, raw dividend remainder
  assign quotient  = div_zero ? 32'hFFFF_FFFF : neg_if(q_neg, quo);
  assign remainder = div_zero ? raw_dividend  : neg_if(r_neg, rem);

endmodule

// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline: ID/EX register, ALU, data-SRAM
// request, EX forwarding bus, HI/LO registers and an iterative divider.
// Optional macro EX_MULT_EN enables single-cycle mult/multu into {HI,LO};
// without it mult/multu are NOPs.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DIV_CYCLES = ex_stage_pkg::DIV_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
  output logic                    ex_is_load,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    stallreq_for_ex
);

  id_ex_t      id_ex;
  logic [31:0] hi;
  logic [31:0] lo;

  // ID/EX pipeline register: bubble when ID stops but EX moves, load when ID moves
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_ex <= '0;
    end else if (stall[STALL_ID] && !stall[STALL_EX]) begin
      id_ex <= '0;
    end else if (!stall[STALL_ID]) begin
      id_ex <= id_ex_t'(id_to_ex_bus);
    end
  end

  // HI/LO instruction decode
  logic [5:0] funct;
  logic       special;
  logic       is_div, is_divu, is_mfhi, is_mflo, is_mthi, is_mtlo, is_mult, is_multu;
  logic       div_present;

  assign funct       = id_ex.inst[5:0];
  assign special     = (id_ex.inst[31:26] == 6'd0);
  assign is_div      = special && (funct == FN_DIV);
  assign is_divu     = special && (funct == FN_DIVU);
  assign is_mfhi     = special && (funct == FN_MFHI);
  assign is_mflo     = special && (funct == FN_MFLO);
  assign is_mthi     = special && (funct == FN_MTHI);
  assign is_mtlo     = special && (funct == FN_MTLO);
  assign is_mult     = special && (funct == FN_MULT);
  assign is_multu    = special && (funct == FN_MULTU);
  assign div_present = is_div | is_divu;

  // One-hot operand select
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic [31:0] src1;
  logic [31:0] src2;

  assign imm_sext = {{16{id_ex.inst[15]}}, id_ex.inst[15:0]};
  assign imm_zext = {16'd0, id_ex.inst[15:0]};

  assign src1 = ({32{id_ex.sel_src1[0]}} & id_ex.rdata1)
              | ({32{id_ex.sel_src1[1]}} & id_ex.pc)
              | ({32{id_ex.sel_src1[2]}} & {27'd0, id_ex.inst[10:6]});

  assign src2 = ({32{id_ex.sel_src2[0]}} & id_ex.rdata2)
              | ({32{id_ex.sel_src2[1]}} & imm_sext)
              | ({32{id_ex.sel_src2[2]}} & 32'd8)
              | ({32{id_ex.sel_src2[3]}} & imm_zext);

  // ALU: OR of the one-hot selected operation results
  logic [4:0]  shamt;
  logic [31:0] alu_result;

  assign shamt = src1[4:0];

  always_comb begin
    // NOTE: default first so every path assigns alu_result and no latch is inferred.
    alu_result = 32'd0;
    if (id_ex.alu_op[OP_ADD])  alu_result = alu_result | (src1 + src2);
    if (id_ex.alu_op[OP_SUB])  alu_result = alu_result | (src1 - src2);
    if (id_ex.alu_op[OP_SLT])  alu_result = alu_result | {31'd0, $signed(src1) < $signed(src2)};
    if (id_ex.alu_op[OP_SLTU]) alu_result = alu_result | {31'd0, src1 < src2};
    if (id_ex.alu_op[OP_AND])  alu_result = alu_result | (src1 & src2);
    if (id_ex.alu_op[OP_NOR])  alu_result = alu_result | ~(src1 | src2);
    if (id_ex.alu_op[OP_OR])   alu_result = alu_result | (src1 | src2);
    if (id_ex.alu_op[OP_XOR])  alu_result = alu_result | (src1 ^ src2);
    if (id_ex.alu_op[OP_SLL])  alu_result = alu_result | (src2 << shamt);
    if (id_ex.alu_op[OP_SRL])  alu_result = alu_result | (src2 >> shamt);
    if (id_ex.alu_op[OP_SRA])  alu_result = alu_result | 32'($signed(src2) >>> shamt);
    if (id_ex.alu_op[OP_LUI])  alu_result = alu_result | (src2 << 16);
  end

  // Writeback fields: mfhi/mflo override, HI/LO writers never touch the RF
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] result;

  always_comb begin
    rf_we    = id_ex.rf_we;
    rf_waddr = id_ex.rf_waddr;
    result   = alu_result;
    if (is_mfhi || is_mflo) begin
      rf_we    = 1'b1;
      rf_waddr = id_ex.inst[15:11];
      result   = is_mfhi ? hi : lo;
    end
    if (div_present || is_mult || is_multu || is_mthi || is_mtlo) begin
      rf_we = 1'b0;
    end
  end

  // Divider
  logic        div_idle;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;

  ex_stage_div_iter #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (div_present),
    .is_signed (is_div),
    .dividend  (id_ex.rdata1),
    .divisor   (id_ex.rdata2),
    .idle      (div_idle),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quotient),
    .remainder (div_remainder)
  );

  // Held in the setup cycle and every iteration; released in DONE so the
  // pipe advances on the same edge that writes HI/LO.
  assign stallreq_for_ex = (div_idle & div_present) | div_busy;

`ifdef EX_MULT_EN
  logic [63:0] product;
  assign product = is_mult ? 64'($signed(id_ex.rdata1) * $signed(id_ex.rdata2))
                           : ({32'd0, id_ex.rdata1} * {32'd0, id_ex.rdata2});
`endif

  // HI/LO: divider result at DONE, move-to/multiply on a non-held edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi <= '0;
      lo <= '0;
    end else if (div_done) begin
      hi <= div_remainder;
      lo <= div_quotient;
    end else if (!stall[STALL_EX]) begin
      if (is_mthi) hi <= id_ex.rdata1;
      if (is_mtlo) lo <= id_ex.rdata1;
`ifdef EX_MULT_EN
      if (is_mult || is_multu) begin
        hi <= product[63:32];
        lo <= product[31:0];
      end
`endif
    end
  end

  // Memory request and forward/downstream buses
  assign data_sram_en    = id_ex.ram_en;
  assign data_sram_wen   = (id_ex.ram_wen != 4'd0) ? 4'b1111 : 4'b0000;
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = id_ex.rdata2;
  assign ex_is_load      = id_ex.sel_rf_res;

  assign ex_to_mem_bus = {id_ex.pc, id_ex.ram_en, id_ex.ram_wen, id_ex.sel_rf_res,
                          rf_we, rf_waddr, result};
  assign ex_to_rf_bus  = {rf_we, rf_waddr, result};

  // Fields carried on the bus but not consumed in EX
  logic unused_bits;
  assign unused_bits = ^{id_ex.reserved, id_ex.inst[25:16], stall[5:4], stall[1:0]};

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage: ALU, bubbles/holds, memory request,
// div/divu latency and results, reset abort, HI/LO moves and optional mult.
module tb_ex_stage;

  logic         clk;
  logic         rst;
  logic [5:0]   stall;
  logic [5:0]   stall_ext;
  logic [159:0] id_to_ex_bus;
  logic [75:0]  ex_to_mem_bus;
  logic [37:0]  ex_to_rf_bus;
  logic         ex_is_load;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         stallreq_for_ex;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int cnt;

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .id_to_ex_bus    (id_to_ex_bus),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .ex_to_rf_bus    (ex_to_rf_bus),
    .ex_is_load      (ex_is_load),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .stallreq_for_ex (stallreq_for_ex)
  );

  // Stall controller model: divider stall stops stages 0-3
  assign stall = stallreq_for_ex ? 6'b001111 : stall_ext;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [75:0] obs, input logic [75:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] mk(
    input logic [31:0] pc, input logic [31:0] inst, input logic [11:0] op,
    input logic [2:0] s1, input logic [3:0] s2, input logic ram_en,
    input logic [3:0] ram_wen, input logic rf_we, input logic [4:0] waddr,
    input logic sel_rf_res, input logic [31:0] rd1, input logic [31:0] rd2);
    return {1'b0, pc, inst, op, s1, s2, ram_en, ram_wen, rf_we, waddr, sel_rf_res, rd1, rd2};
  endfunction

  function automatic logic [31:0] special(input logic [4:0] rd, input logic [4:0] sa,
                                          input logic [5:0] fn);
    return {6'd0, 5'd1, 5'd2, rd, sa, fn};
  endfunction

  // Present a bus and let one edge load it into EX; sample 1 time unit later
  task automatic issue(input logic [159:0] bus);
    id_to_ex_bus = bus;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_div(input string tag);
    cnt = 0;
    while (stallreq_for_ex && cnt < 100) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    check(tag, 76'(cnt), 76'd33);
  endtask

  localparam logic [11:0] A_ADD  = 12'b1000_0000_0000;
  localparam logic [11:0] A_SUB  = 12'b0100_0000_0000;
  localparam logic [11:0] A_SLT  = 12'b0010_0000_0000;
  localparam logic [11:0] A_SLTU = 12'b0001_0000_0000;
  localparam logic [11:0] A_NOR  = 12'b0000_0100_0000;
  localparam logic [11:0] A_SRA  = 12'b0000_0000_0010;
  localparam logic [11:0] A_LUI  = 12'b0000_0000_0001;

  logic [159:0] b_mfhi;
  logic [159:0] b_mflo;

  initial begin
    rst          = 1'b0;
    stall_ext    = 6'd0;
    id_to_ex_bus = '0;
    b_mfhi = mk(32'h0, special(5'd4, 5'd0, 6'h10), 12'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    b_mflo = mk(32'h0, special(5'd3, 5'd0, 6'h12), 12'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_bus",  ex_to_mem_bus, 76'd0);
    check("rst_rf_bus",   76'(ex_to_rf_bus), 76'd0);
    check("rst_stallreq", 76'(stallreq_for_ex), 76'd0);
    check("rst_sram_en",  76'(data_sram_en), 76'd0);
    @(negedge clk);
    rst = 1'b1;

    // addiu rt=9, 5 + 0xFFFF(-1) = 4
    issue(mk(32'hBFC0_0000, {6'h09, 5'd1, 5'd9, 16'hFFFF}, A_ADD, 3'b001, 4'b0010,
             1'b0, 4'd0, 1'b1, 5'd9, 1'b0, 32'd5, 32'd0));
    check("addiu_rf_bus", 76'(ex_to_rf_bus), 76'({1'b1, 5'd9, 32'h4}));
    check("addiu_load",   76'(ex_is_load), 76'd0);

    // ID stopped, EX moving: bubble enters EX
    stall_ext = 6'b000100;
    @(posedge clk);
    #1;
    check("bubble_rf_we",   76'(ex_to_mem_bus[37]), 76'd0);
    check("bubble_sram_en", 76'(data_sram_en), 76'd0);
    check("bubble_mem_bus", ex_to_mem_bus, 76'd0);
    stall_ext = 6'd0;

    // sw: addr = 0x100 + 8
    issue(mk(32'hBFC0_0008, {6'h2B, 5'd1, 5'd2, 16'h0008}, A_ADD, 3'b001, 4'b0010,
             1'b1, 4'hF, 1'b0, 5'd0, 1'b0, 32'h100, 32'hDEAD_BEEF));
    check("sw_en",    76'(data_sram_en), 76'd1);
    check("sw_wen",   76'(data_sram_wen), 76'hF);
    check("sw_addr",  76'(data_sram_addr), 76'h108);
    check("sw_wdata", 76'(data_sram_wdata), 76'hDEAD_BEEF);

    // lw: load flag, no write enables
    issue(mk(32'hBFC0_000C, {6'h23, 5'd1, 5'd7, 16'hFFFC}, A_ADD, 3'b001, 4'b0010,
             1'b1, 4'h0, 1'b1, 5'd7, 1'b1, 32'h200, 32'd0));
    check("lw_load", 76'(ex_is_load), 76'd1);
    check("lw_wen",  76'(data_sram_wen), 76'd0);
    check("lw_addr", 76'(data_sram_addr), 76'h1FC);

    // ALU operations
    issue(mk(32'h0, special(5'd5, 5'd0, 6'h23), A_SUB, 3'b001, 4'b0001,
             1'b0, 4'd0, 1'b1, 5'd5, 1'b0, 32'd3, 32'd5));
    check("sub", 76'(ex_to_rf_bus[31:0]), 76'hFFFF_FFFE);
    issue(mk(32'h0, special(5'd5, 5'd0, 6'h2A), A_SLT, 3'b001, 4'b0001,
             1'b0, 4'd0, 1'b1, 5'd5, 1'b0, 32'hFFFF_FFFF, 32'd1));
    check("slt", 76'(ex_to_rf_bus[31:0]), 76'd1);
    issue(mk(32'h0, special(5'd5, 5'd0, 6'h2B), A_SLTU, 3'b001, 4'b0001,
             1'b0, 4'd0, 1'b1, 5'd5, 1'b0, 32'hFFFF_FFFF, 32'd1));
    check("sltu", 76'(ex_to_rf_bus[31:0]), 76'd0);
    issue(mk(32'h0, special(5'd5, 5'd0, 6'h27), A_NOR, 3'b001, 4'b0001,
             1'b0, 4'd0, 1'b1, 5'd5, 1'b0, 32'hF0F0_F0F0, 32'h0F0F_0000));
    check("nor", 76'(ex_to_rf_bus[31:0]), 76'h0000_0F0F);
    issue(mk(32'h0, special(5'd5, 5'd4, 6'h03), A_SRA, 3'b100, 4'b0001,
             1'b0, 4'd0, 1'b1, 5'd5, 1'b0, 32'd0, 32'h8000_0000));
    check("sra", 76'(ex_to_rf_bus[31:0]), 76'hF800_0000);
    issue(mk(32'h0, {6'h0F, 5'd0, 5'd6, 16'h1234}, A_LUI, 3'b000, 4'b1000,
             1'b0, 4'd0, 1'b1, 5'd6, 1'b0, 32'd0, 32'd0));
    check("lui", 76'(ex_to_rf_bus), 76'({1'b1, 5'd6, 32'h1234_0000}));
    issue(mk(32'hBFC0_0010, {6'h03, 26'd0}, A_ADD, 3'b010, 4'b0100,
             1'b0, 4'd0, 1'b1, 5'd31, 1'b0, 32'd0, 32'd0));
    check("jal_link", 76'(ex_to_rf_bus[31:0]), 76'hBFC0_0018);

    // ID and EX both stopped: EX holds the link instruction
    stall_ext = 6'b001100;
    issue(mk(32'h0, special(5'd5, 5'd0, 6'h23), A_SUB, 3'b001, 4'b0001,
             1'b0, 4'd0, 1'b1, 5'd5, 1'b0, 32'd1, 32'd1));
    check("hold", 76'(ex_to_rf_bus), 76'({1'b1, 5'd31, 32'hBFC0_0018}));
    stall_ext = 6'd0;

    // div -7 / 2 -> q=-3, r=-1
    issue(mk(32'h0, special(5'd0, 5'd0, 6'h1A), 12'd0, 3'd0, 4'd0,
             1'b0, 4'd0, 1'b0, 5'd0, 1'b0, 32'hFFFF_FFF9, 32'd2));
    check("div_stallreq", 76'(stallreq_for_ex), 76'd1);
    check("div_rf_we",    76'(ex_to_rf_bus[37]), 76'd0);
    check("div_mem_we",   76'(ex_to_mem_bus[37]), 76'd0);
    id_to_ex_bus = b_mflo;
    wait_div("div_latency");
    @(posedge clk);
    #1;
    check("div_mflo", 76'(ex_to_rf_bus), 76'({1'b1, 5'd3, 32'hFFFF_FFFD}));
    issue(b_mfhi);
    check("div_mfhi", 76'(ex_to_rf_bus), 76'({1'b1, 5'd4, 32'hFFFF_FFFF}));

    // divu 10 / 0 -> LO all ones, HI = dividend
    issue(mk(32'h0, special(5'd0, 5'd0, 6'h1B), 12'd0, 3'd0, 4'd0,
             1'b0, 4'd0, 1'b0, 5'd0, 1'b0, 32'd10, 32'd0));
    id_to_ex_bus = b_mflo;
    wait_div("divz_latency");
    @(posedge clk);
    #1;
    check("divz_mflo", 76'(ex_to_rf_bus[31:0]), 76'hFFFF_FFFF);
    issue(b_mfhi);
    check("divz_mfhi", 76'(ex_to_rf_bus[31:0]), 76'd10);

    // divu aborted by reset in BUSY cycle 5
    issue(mk(32'h0, special(5'd0, 5'd0, 6'h1B), 12'd0, 3'd0, 4'd0,
             1'b0, 4'd0, 1'b0, 5'd0, 1'b0, 32'd100, 32'd7));
    repeat (5) @(posedge clk);
    #1;
    check("abort_busy", 76'(stallreq_for_ex), 76'd1);
    rst = 1'b0;
    #1;
    check("abort_stallreq", 76'(stallreq_for_ex), 76'd0);
    @(negedge clk);
    rst = 1'b1;
    issue(b_mfhi);
    check("abort_hi", 76'(ex_to_rf_bus[31:0]), 76'd0);
    issue(b_mflo);
    check("abort_lo", 76'(ex_to_rf_bus[31:0]), 76'd0);
    check("abort_stall_after", 76'(stallreq_for_ex), 76'd0);

    // mthi / mtlo
    issue(mk(32'h0, special(5'd0, 5'd0, 6'h11), 12'd0, 3'd0, 4'd0,
             1'b0, 4'd0, 1'b0, 5'd0, 1'b0, 32'h1111_2222, 32'd0));
    check("mthi_rf_we", 76'(ex_to_rf_bus[37]), 76'd0);
    issue(mk(32'h0, special(5'd0, 5'd0, 6'h13), 12'd0, 3'd0, 4'd0,
             1'b0, 4'd0, 1'b0, 5'd0, 1'b0, 32'h3333_4444, 32'd0));
    issue(b_mfhi);
    check("mthi_val", 76'(ex_to_rf_bus[31:0]), 76'h1111_2222);
    issue(b_mflo);
    check("mtlo_val", 76'(ex_to_rf_bus[31:0]), 76'h3333_4444);

    // mult 0x80000000 * 2
    issue(mk(32'h0, special(5'd0, 5'd0, 6'h18), 12'd0, 3'd0, 4'd0,
             1'b0, 4'd0, 1'b0, 5'd0, 1'b0, 32'h8000_0000, 32'd2));
    issue(b_mfhi);
`ifdef EX_MULT_EN
    check("mult_hi", 76'(ex_to_rf_bus[31:0]), 76'hFFFF_FFFF);
`else
    check("mult_hi", 76'(ex_to_rf_bus[31:0]), 76'h1111_2222);
`endif
    issue(b_mflo);
`ifdef EX_MULT_EN
    check("mult_lo", 76'(ex_to_rf_bus[31:0]), 76'h0);
`else
    check("mult_lo", 76'(ex_to_rf_bus[31:0]), 76'h3333_4444);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
